// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg : shared types and constants for the mul/div sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package muldiv_pkg;

    localparam int unsigned MULDIV_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam logic [MULDIV_XLEN-1:0] XLEN_MIN_INT = 32'h8000_0000;
    localparam logic [MULDIV_XLEN-1:0] ALL_ONES     = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/muldiv_special.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_special : combinational divide-by-zero / overflow resolver  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_special
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_special,
    output logic [XLEN-1:0] special_res
);

    logic w_b_zero;
    logic w_overflow;

    always_comb begin
        w_b_zero    = (b == '0);
        // Only the signed forms overflow; DIVU/REMU of the same bits are ordinary.
        w_overflow  = ((op == DIV) || (op == REM)) && (a == XLEN_MIN_INT) && (b == ALL_ONES);
        is_special  = op[2] && (w_b_zero || w_overflow);
        special_res = '0;
        if (op[2] && w_b_zero) begin
            special_res = op[1] ? a : ALL_ONES;
        end else if (w_overflow) begin
            special_res = (op == DIV) ? XLEN_MIN_INT : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_sched : RV32M sequencer for the shared iterative engine     |
// | Optional one-entry result cache under MULDIV_OPCACHE_EN. Rev 1.0   |
// +--------------------------------------------------------------------+
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic            issue,
    input  logic [2:0]      op_sel,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            hold,
    input  logic            flush,
    output logic            eng_start,
    output logic            eng_abort,
    output logic [2:0]      eng_op,
    output logic [XLEN-1:0] eng_a,
    output logic [XLEN-1:0] eng_b,
    input  logic            eng_done,
    input  logic [XLEN-1:0] eng_res,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd,
    output logic            mul_ready,
    output logic            div_ready,
    output logic            busy
);

    muldiv_state_t   r_state;
    muldiv_state_t   w_state_next;

    logic            w_accept;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_res;
    logic            w_enter_done;

    logic            w_start_d;
    logic            w_abort_d;
    logic [2:0]      w_op_d;
    logic [XLEN-1:0] w_a_d;
    logic [XLEN-1:0] w_b_d;
    logic [4:0]      w_rd_d;
    logic [XLEN-1:0] w_res_d;
    logic            w_mul_ready_d;
    logic            w_div_ready_d;
    logic            w_busy_d;

    muldiv_special #(.XLEN(XLEN)) u_special (
        .op          (op_sel),
        .a           (rs1_val),
        .b           (rs2_val),
        .is_special  (w_special),
        .special_res (w_special_res)
    );

    assign w_accept = (r_state == ST_IDLE) && issue && !hold && !flush;

`ifdef MULDIV_OPCACHE_EN
    logic            r_c_valid;
    logic [2:0]      r_c_op;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_res;

    always_comb begin
        w_hit     = r_c_valid && (op_sel == r_c_op) && (rs1_val == r_c_a) && (rs2_val == r_c_b);
        w_hit_res = r_c_res;
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_c_valid <= 1'b0;
            r_c_op    <= '0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_res   <= '0;
        end else if (w_enter_done) begin
            r_c_valid <= 1'b1;
            r_c_op    <= w_op_d;
            r_c_a     <= w_a_d;
            r_c_b     <= w_b_d;
            r_c_res   <= w_res_d;
        end
    end
`else
    always_comb begin
        w_hit     = 1'b0;
        w_hit_res = '0;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush outranks everything, including a coincident eng_done
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_special || w_hit) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (eng_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || !hold) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_start_d = w_accept && !w_special && !w_hit;
        w_abort_d = (r_state == ST_RUN) && flush;
        w_op_d    = w_accept ? op_sel  : eng_op;
        w_a_d     = w_accept ? rs1_val : eng_a;
        w_b_d     = w_accept ? rs2_val : eng_b;
        w_rd_d    = w_accept ? rd_in   : result_rd;
        w_res_d   = result;
        if (w_accept && w_special) begin
            w_res_d = w_special_res;
        end else if (w_accept && w_hit) begin
            w_res_d = w_hit_res;
        end else if ((r_state == ST_RUN) && eng_done && !flush) begin
            w_res_d = eng_res;
        end
        w_enter_done  = (w_state_next == ST_DONE) && (r_state != ST_DONE);
        w_mul_ready_d = (w_state_next == ST_DONE) && !w_op_d[2];
        w_div_ready_d = (w_state_next == ST_DONE) &&  w_op_d[2];
        w_busy_d      = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            eng_op    <= '0;
            eng_a     <= '0;
            eng_b     <= '0;
            result    <= '0;
            result_rd <= '0;
            mul_ready <= 1'b0;
            div_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            eng_start <= w_start_d;
            eng_abort <= w_abort_d;
            eng_op    <= w_op_d;
            eng_a     <= w_a_d;
            eng_b     <= w_b_d;
            result    <= w_res_d;
            result_rd <= w_rd_d;
            mul_ready <= w_mul_ready_d;
            div_ready <= w_div_ready_d;
            busy      <= w_busy_d;
        end
    end

endmodule
`default_nettype wire
